pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 192, payload width (Instruction, RD, Result, RegAddr, imm32, HILO, CP0 packed by instantiator).
REQ-002 SHALL have parameter PC_W, default 32, program-counter width.
REQ-003 SHALL have parameter EXC_PC, default 32'h0000_4180, handler address loaded on req.
REQ-004 SHALL have parameter RESET_PC, default 0, out_pc value after reset and on flush.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports, in order:
  clk  input  1  rising-edge clock.
  reset  input  1  asynchronous, active-low reset.
  req  input  1  exception redirect, highest priority.
  flush  input  1  pipeline bubble, below req.
  in_valid  input  1  upstream entry present.
  in_ready  output  1  stage can accept.
  in_pc  input  PC_W  upstream PC.
  in_data  input  DATA_W  upstream payload.
  out_valid  output  1  entry presented downstream.
  out_ready  input  1  downstream accepts.
  out_pc  output  PC_W  presented PC.
  out_data  output  DATA_W  presented payload.
  out_exc  output  1  presented slot is an injected exception bubble.
  occupancy  output  2  entries held, 0..2.

Function
REQ-007 SHALL hold two entries: output register (O) driving out_*, and skid register (S).
REQ-008 SHALL drive in_ready = !S.valid && !req && !flush, combinationally from registered S.valid.
REQ-009 SHALL define accept = in_valid && in_ready; consume = out_valid && out_ready.
REQ-010 SHALL, when O empty or consume, load O from S if S.valid (S cleared), else from input if accept, else clear O.valid.
REQ-011 SHALL, when O valid and not consume and accept, write input into S.
REQ-012 SHALL never accept and load S->O in the same cycle (guaranteed by REQ-008).
REQ-013 SHALL pass data with 1-cycle latency empty-to-output; no entry is dropped or duplicated under any out_ready pattern.
REQ-014 SHALL, on req, in the following cycle: O.valid=0, out_pc=EXC_PC, out_data=0, out_exc=1, S cleared; any coincident input discarded.
REQ-015 SHALL, on flush without req: O.valid=0, out_pc=RESET_PC, out_data=0, out_exc=0, S cleared.
REQ-016 SHALL, when req and flush coincide, apply req only.
REQ-017 SHALL clear out_exc when O next loads a valid entry; hold out_exc=1 while O stays empty.
REQ-018 SHALL keep out_pc/out_data stable while out_valid=1 and out_ready=0.
REQ-019 SHALL drive occupancy = O.valid + S.valid, registered-state derived.
REQ-020 SHALL not gate out_valid with out_ready (no combinational ready->valid path).

Reset
REQ-021 SHALL, while reset=0, immediately force O.valid=0, S.valid=0, out_pc=RESET_PC, out_data=0, out_exc=0, occupancy=0, independent of clk.
REQ-022 SHALL, after reset deasserts, accept input on the first rising edge (in_ready=1).
REQ-023 SHALL, on reset mid-transfer, discard both entries with no partial update.

Verification
REQ-024 Stream: out_ready=1, in_valid=1, in_pc 0x3000,0x3004,0x3008 -> out_pc same order one cycle later, occupancy=1, in_ready=1.
REQ-025 Backpressure: out_ready=0, push 0x3000 then 0x3004 -> occupancy=2, in_ready=0, out_pc=0x3000 held; raise out_ready -> 0x3000, 0x3004 emitted, no loss.
REQ-026 Exception: occupancy=2, pulse req -> next cycle out_valid=0, out_pc=0x0000_4180, out_data=0, out_exc=1, occupancy=0; next accepted 0x4180 clears out_exc.
REQ-027 Priority: req and flush together with in_valid=1 -> out_pc=0x0000_4180, out_exc=1, input dropped.
REQ-028 Async reset: assert reset=0 between edges with occupancy=2 -> outputs zero/RESET_PC before next edge; release -> in_ready=1.
REQ-029 Random: random in_valid/out_ready 10k cycles vs scoreboard -> output sequence equals accepted input sequence.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage: output register O plus skid register S, with
// exception-redirect (req) and bubble (flush) injection on the output slot.
module pipe_skid_reg #(
  parameter int              DATA_W   = 192,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] EXC_PC   = 32'h0000_4180,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_exc,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t o_q, o_d;
  ent_t s_q, s_d;
  logic exc_q, exc_d;
  logic accept, consume;

  // Ready depends only on registered S plus the redirect inputs, never on out_ready.
  assign in_ready  = !s_q.valid && !req && !flush;
  assign accept    = in_valid && in_ready;
  assign consume   = o_q.valid && out_ready;

  assign out_valid = o_q.valid;
  assign out_pc    = o_q.pc;
  assign out_data  = o_q.data;
  assign out_exc   = exc_q;
  assign occupancy = {1'b0, o_q.valid} + {1'b0, s_q.valid};

  always_comb begin
    o_d   = o_q;
    s_d   = s_q;
    exc_d = exc_q;
    if (req) begin
      o_d   = '{valid: 1'b0, pc: EXC_PC, data: '0};
      s_d.valid = 1'b0;
      exc_d = 1'b1;
    end else if (flush) begin
      o_d   = '{valid: 1'b0, pc: RESET_PC, data: '0};
      s_d.valid = 1'b0;
      exc_d = 1'b0;
    end else if (!o_q.valid || consume) begin
      // S always drains before new input; in_ready blocks accept while S is full.
      if (s_q.valid) begin
        o_d       = s_q;
        s_d.valid = 1'b0;
        exc_d     = 1'b0;
      end else if (accept) begin
        o_d   = '{valid: 1'b1, pc: in_pc, data: in_data};
        exc_d = 1'b0;
      end else begin
        o_d.valid = 1'b0;
      end
    end else if (accept) begin
      s_d = '{valid: 1'b1, pc: in_pc, data: in_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_q   <= '{valid: 1'b0, pc: RESET_PC, data: '0};
      s_q   <= '{valid: 1'b0, pc: '0, data: '0};
      exc_q <= 1'b0;
    end else begin
      o_q   <= o_d;
      s_q   <= s_d;
      exc_q <= exc_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized and directed bench for pipe_skid_reg; reference is a plain
// two-deep FIFO queue with redirect/bubble rules applied per clock.
module tb_pipe_skid_reg;
  localparam int DW = 192;
  localparam int PW = 32;
  localparam logic [PW-1:0] EXC = 32'h0000_4180;
  localparam logic [PW-1:0] RST = 32'h0;

  logic          clk = 1'b0;
  logic          reset, req, flush, in_valid, in_ready, out_valid, out_ready, out_exc;
  logic [PW-1:0] in_pc, out_pc;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;

  pipe_skid_reg dut (
    .clk(clk), .reset(reset), .req(req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .out_exc(out_exc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] pc; logic [DW-1:0] data; } ent_t;

  ent_t          mq[$];
  ent_t          acc_log[$];
  ent_t          dut_log[$];
  logic [PW-1:0] m_pc;
  logic [DW-1:0] m_data;
  logic          m_exc;
  int            n_chk = 0;
  int            n_fail = 0;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pc = RST; m_data = '0; m_exc = 1'b0;
  endfunction

  // Drive one cycle, advance the reference, land 1 time unit after the edge.
  task automatic cycle(input logic v, input logic [PW-1:0] pc, input logic [DW-1:0] d,
                       input logic ordy, input logic rq, input logic fl);
    ent_t e;
    logic acc;
    in_valid = v; in_pc = pc; in_data = d; out_ready = ordy; req = rq; flush = fl;
    if (out_valid && ordy && !rq && !fl) dut_log.push_back('{out_pc, out_data});
    @(posedge clk);
    if (rq) begin
      mq.delete(); m_pc = EXC; m_data = '0; m_exc = 1'b1;
    end else if (fl) begin
      mq.delete(); m_pc = RST; m_data = '0; m_exc = 1'b0;
    end else begin
      acc = v && (mq.size() < 2);
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (acc) begin
        e.pc = pc; e.data = d;
        mq.push_back(e);
        acc_log.push_back(e);
      end
      if (mq.size() > 0) begin
        m_pc = mq[0].pc; m_data = mq[0].data; m_exc = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 0; flush = 0; in_valid = 0; out_ready = 0; in_pc = '0; in_data = '0;
    model_reset();
    #2;
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== RST || out_data !== '0 || out_exc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b occ=%0d pc=%h exc=%b, want 0 0 %h 0", out_valid, occupancy, out_pc, out_exc, RST);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [PW-1:0] pcs [3];
    logic [DW-1:0] d;
    pcs[0] = 32'h3000; pcs[1] = 32'h3004; pcs[2] = 32'h3008;
    for (int i = 0; i < 3; i++) begin
      d = rnd_data();
      cycle(1, pcs[i], d, 1, 0, 0);
      n_chk++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_data !== d || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b pc=%h occ=%0d rdy=%b, want 1 %h 1 1", i, out_valid, out_pc, occupancy, in_ready, pcs[i]);
      end
    end
    cycle(0, '0, '0, 1, 0, 0);
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL stream_drain: valid=%b occ=%0d want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d0, d1;
    d0 = rnd_data(); d1 = rnd_data();
    cycle(1, 32'h3000, d0, 0, 0, 0);
    cycle(1, 32'h3004, d1, 0, 0, 0);
    n_chk++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h3000 || out_data !== d0) begin
      n_fail++; $display("FAIL bp_full: occ=%0d rdy=%b pc=%h want 2 0 3000", occupancy, in_ready, out_pc);
    end
    cycle(1, 32'h3008, rnd_data(), 0, 0, 0);
    n_chk++;
    if (occupancy !== 2'd2 || out_pc !== 32'h3000 || out_data !== d0) begin
      n_fail++; $display("FAIL bp_hold: occ=%0d pc=%h want 2 3000", occupancy, out_pc);
    end
    cycle(0, '0, '0, 1, 0, 0);
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 32'h3004 || out_data !== d1 || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL bp_second: valid=%b pc=%h occ=%0d want 1 3004 1", out_valid, out_pc, occupancy);
    end
    cycle(0, '0, '0, 1, 0, 0);
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++; $display("FAIL bp_drain: valid=%b occ=%0d want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_exception();
    logic [DW-1:0] d;
    cycle(1, 32'h3100, rnd_data(), 0, 0, 0);
    cycle(1, 32'h3104, rnd_data(), 0, 0, 0);
    cycle(1, 32'h3108, rnd_data(), 0, 1, 0);
    n_chk++;
    if (out_valid !== 1'b0 || out_pc !== EXC || out_data !== '0 || out_exc !== 1'b1 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL exc_inject: valid=%b pc=%h exc=%b occ=%0d want 0 %h 1 0", out_valid, out_pc, out_exc, occupancy, EXC);
    end
    cycle(0, '0, '0, 1, 0, 0);
    n_chk++;
    if (out_exc !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL exc_hold: exc=%b valid=%b want 1 0", out_exc, out_valid);
    end
    d = rnd_data();
    cycle(1, EXC, d, 0, 0, 0);
    n_chk++;
    if (out_valid !== 1'b1 || out_exc !== 1'b0 || out_pc !== EXC || out_data !== d) begin
      n_fail++; $display("FAIL exc_clear: valid=%b exc=%b pc=%h want 1 0 %h", out_valid, out_exc, out_pc, EXC);
    end
    cycle(0, '0, '0, 1, 0, 0);
  endtask

  task automatic test_priority();
    cycle(1, 32'h3200, rnd_data(), 0, 0, 0);
    cycle(1, 32'h5000, rnd_data(), 0, 1, 1);
    n_chk++;
    if (out_valid !== 1'b0 || out_pc !== EXC || out_exc !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
      n_fail++; $display("FAIL prio_req: valid=%b pc=%h exc=%b occ=%0d want 0 %h 1 0", out_valid, out_pc, out_exc, occupancy, EXC);
    end
    cycle(0, '0, '0, 1, 0, 0);
    n_chk++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL prio_dropped: occ=%0d valid=%b want 0 0", occupancy, out_valid);
    end
    cycle(1, 32'h3300, rnd_data(), 0, 0, 0);
    cycle(0, '0, '0, 0, 0, 1);
    n_chk++;
    if (out_valid !== 1'b0 || out_pc !== RST || out_exc !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin
      n_fail++; $display("FAIL flush: valid=%b pc=%h exc=%b occ=%0d want 0 %h 0 0", out_valid, out_pc, out_exc, occupancy, RST);
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] d;
    cycle(1, 32'h3400, rnd_data(), 0, 0, 0);
    cycle(1, 32'h3404, rnd_data(), 0, 0, 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== RST || out_data !== '0 || out_exc !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: valid=%b occ=%0d pc=%h exc=%b want 0 0 %h 0", out_valid, occupancy, out_pc, out_exc, RST);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_release_ready: got %b want 1", in_ready);
    end
    d = rnd_data();
    cycle(1, 32'h6000, d, 1, 0, 0);
    n_chk++;
    if (out_valid !== 1'b1 || out_pc !== 32'h6000 || out_data !== d || occupancy !== 2'd1) begin
      n_fail++; $display("FAIL async_first_accept: valid=%b pc=%h occ=%0d want 1 6000 1", out_valid, out_pc, occupancy);
    end
    cycle(0, '0, '0, 1, 0, 0);
  endtask

  task automatic test_random(input int ncyc, input int redirect_pct);
    logic v, o, rq, fl;
    int   bad;
    for (int i = 0; i < ncyc; i++) begin
      v  = ($urandom_range(99) < 60);
      o  = ($urandom_range(99) < 55);
      rq = ($urandom_range(99) < redirect_pct);
      fl = ($urandom_range(99) < redirect_pct);
      cycle(v, $urandom, rnd_data(), o, rq, fl);
      n_chk++;
      if (out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size()) ||
          in_ready !== ((mq.size() < 2) && !rq && !fl) || out_exc !== m_exc ||
          out_pc !== m_pc || out_data !== m_data) begin
        n_fail++;
        $display("FAIL rand_cycle_%0d: valid=%b occ=%0d rdy=%b exc=%b pc=%h, want %b %0d %b %b %h", i,
                 out_valid, occupancy, in_ready, out_exc, out_pc, mq.size() > 0, mq.size(),
                 (mq.size() < 2) && !rq && !fl, m_exc, m_pc);
      end
    end
  endtask

  task automatic test_random_sequence();
    int bad;
    cycle(0, '0, '0, 0, 0, 1);
    acc_log.delete(); dut_log.delete();
    test_random(10000, 0);
    while (mq.size() > 0) cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    bad = 0;
    for (int i = 0; i < dut_log.size() && i < acc_log.size(); i++)
      if (dut_log[i].pc !== acc_log[i].pc || dut_log[i].data !== acc_log[i].data) bad++;
    n_chk++;
    if (bad != 0 || dut_log.size() != acc_log.size()) begin
      n_fail++;
      $display("FAIL rand_sequence: emitted=%0d mismatched=%0d, want emitted=%0d mismatched=0", dut_log.size(), bad, acc_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_exception();
    test_priority();
    test_async_reset();
    test_random_sequence();
    test_random(2000, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
